// File: rtl/core_pkg.sv
// Shared core types and sizing for the integer register file.
// Optional macro REGFILE_BYPASS_EN selects write-first reads.
package core_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef word_t [NUM_REGS-1:0] reg_array_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port with optional same-cycle write bypass.
// REGFILE_BYPASS_EN defined: write-first; undefined: read-first.
module regfile_read_port
    import core_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_en_i,
    input  reg_addr_t  addr_i,
    input  reg_array_t regs_i,
    input  logic       we_i,
    input  reg_addr_t  wr_addr_i,
    input  word_t      wr_data_i,
    output word_t      data_o
);

    word_t data_q;
    word_t data_d;
    word_t src;

    always_comb begin
        src = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
        if (we_i && (wr_addr_i == addr_i))
            src = wr_data_i;
`endif
        // r0 reads zero even if a bypass matched
        if (addr_i == REG_ZERO)
            src = '0;
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{we_i, wr_addr_i, wr_data_i};
`endif

    always_comb begin
        data_d = data_q;
        if (rd_en_i)
            data_d = src;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            data_q <= '0;
        else
            data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/regfile_64.sv
// 32 x 64-bit register file, two registered read ports, one write port.
// REGFILE_BYPASS_EN selects write-first on same-cycle read/write.
module regfile_64
    import core_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rd_en,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output word_t     rs1_data,
    output word_t     rs2_data,
    output logic      rd_valid,
    input  logic      we,
    input  reg_addr_t wr_addr,
    input  word_t     wr_data,
    output logic      wr_zero_attempt
);

    reg_array_t regs_q;
    logic       rd_valid_q;
    logic       wza_q;
    logic       wza_d;

    assign wza_d = we && (wr_addr == REG_ZERO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '0;
            rd_valid_q <= 1'b0;
            wza_q      <= 1'b0;
        end else begin
            if (we && (wr_addr != REG_ZERO))
                regs_q[wr_addr] <= wr_data;
            rd_valid_q <= rd_en;
            wza_q      <= wza_d;
        end
    end

    regfile_read_port u_rp1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (rd_en),
        .addr_i    (rs1_addr),
        .regs_i    (regs_q),
        .we_i      (we),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .data_o    (rs1_data)
    );

    regfile_read_port u_rp2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en_i   (rd_en),
        .addr_i    (rs2_addr),
        .regs_i    (regs_q),
        .we_i      (we),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .data_o    (rs2_data)
    );

    assign rd_valid        = rd_valid_q;
    assign wr_zero_attempt = wza_q;

endmodule

// File: doc/regfile_64.md
Name: regfile_64

Overview:
- 32-entry x 64-bit integer register file feeding the `a`/`b` operand inputs of the 64-bit ALU.
- Two registered read ports and one write port (ALU writeback).
- Register 0 is hardwired to zero.
- Sits between decode and execute; read data lands one cycle after the address, aligned with the execute stage.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, address width; must equal clog2(NUM_REGS).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- rd_en  in  1  read request; when high, both read ports capture this cycle.
- rs1_addr  in  ADDR_W  read port 1 address.
- rs2_addr  in  ADDR_W  read port 2 address.
- rs1_data  out  DATA_W  read port 1 data, drives ALU `a`.
- rs2_data  out  DATA_W  read port 2 data, drives ALU `b`.
- rd_valid  out  1  high the cycle after an accepted rd_en; read data valid.
- we  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data (ALU result).
- wr_zero_attempt  out  1  pulses one cycle after a write to register 0 is discarded.

Behaviour:
- Reset: clk rising with rst_n=0 clears all NUM_REGS entries, rs1_data, rs2_data, rd_valid and wr_zero_attempt to 0 in that cycle. Reset overrides any same-cycle we/rd_en; no write or read is performed.
- Write: at a rising edge with we=1 and wr_addr!=0, entry[wr_addr] <= wr_data.
- Write to register 0: discarded; entry[0] stays 0; wr_zero_attempt=1 next cycle, otherwise 0.
- Read:
  - At a rising edge with rd_en=1, rs1_data <= entry[rs1_addr] and rs2_data <= entry[rs2_addr].
  - rd_valid <= rd_en; latency is exactly 1 cycle.
  - With rd_en=0, rs1_data/rs2_data hold their last values and rd_valid=0.
- Address 0 read always returns 0.
- Both read ports addressing the same register both return the same value.
- Same-cycle write and read of the same nonzero register: result governed by REGFILE_BYPASS_EN (see below).
- Addresses are always in range: NUM_REGS = 2**ADDR_W, so there is no out-of-range case.
- Back-to-back rd_en every cycle is supported; rd_valid stays high continuously.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-first): if we=1 and wr_addr==rsN_addr!=0 in the read cycle, rsN_data captures wr_data.
- Not defined (read-first): rsN_data captures the pre-write entry contents; the new value is visible on reads issued the following cycle onward.
- Address 0 is never bypassed in either mode.

Decomposition:
- Shared package `core_pkg`:
  - localparams DATA_W, NUM_REGS, ADDR_W;
  - typedef word_t = logic [DATA_W-1:0];
  - typedef reg_addr_t = logic [ADDR_W-1:0];
  - constant REG_ZERO = '0.
- Sub-module `regfile_read_port`: address, storage array view, write-bypass inputs -> registered data; instantiated twice so both ports are identical.

Test Plan:
- Reset: write 64'hDEAD_BEEF to r5, assert rst_n=0 one cycle, then read r5 -> rs1_data=0, rd_valid=0 during reset, rd_valid=1 one cycle after first post-reset rd_en.
- Basic write/read: write r3=64'h0123_4567_89AB_CDEF, r31=64'hFFFF_FFFF_FFFF_FFFF; next cycle read rs1=3, rs2=31 -> rs1_data=64'h0123_4567_89AB_CDEF, rs2_data=all ones, one cycle after rd_en.
- Zero register: write r0=64'h1 -> wr_zero_attempt=1 next cycle; read rs1=0, rs2=0 -> both 0.
- Same-cycle hazard: r7=64'h10, then in one cycle we=1 wr_addr=7 wr_data=64'h20 with rd_en rs1=7 -> rs1_data=64'h20 with REGFILE_BYPASS_EN, 64'h10 without; the read next cycle returns 64'h20 in both builds.
- Hold/stream: rd_en high 4 cycles with changing addresses, then low -> rd_valid high exactly 4 cycles; data holds last value after rd_en drops.
- Dual-port same address: rs1=rs2=12 after writing 64'h8000_0000_0000_0000 -> both outputs equal 64'h8000_0000_0000_0000.
